// File: rtl/button_pkg.sv
// Shared sizing helpers and default parameters for the button event generator.
package button_pkg;

  localparam int DEF_SYNC_STAGES  = 2;
  localparam int DEF_DEBOUNCE_CYC = 16;

  function automatic int cnt_width(input int debounce_cyc);
    return $clog2(debounce_cyc + 1);
  endfunction

  // Repeat counter spans 0 .. delay+rate so the wrap point itself is representable.
  function automatic int rpt_width(input int delay, input int rate);
    return $clog2(delay + rate + 1);
  endfunction

endpackage

// File: rtl/button_channel.sv
// One button channel: synchroniser, stability-counter debounce, press/release
// pulses and optional auto-repeat.
module button_channel
  import button_pkg::*;
#(
  parameter int SYNC_STAGES  = DEF_SYNC_STAGES,
  parameter int DEBOUNCE_CYC = DEF_DEBOUNCE_CYC,
  parameter int REPEAT_DELAY = 0,
  parameter int REPEAT_RATE  = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_in,
  input  logic repeat_en,
  output logic level_o,
  output logic press_o,
  output logic release_o,
  output logic repeat_o
);

  localparam int CW = cnt_width(DEBOUNCE_CYC);

  logic [SYNC_STAGES-1:0] sync;
  logic                   s;
  logic [CW-1:0]          cnt;
  logic [CW-1:0]          cnt_nxt;
  logic                   toggle;

  assign s = sync[SYNC_STAGES-1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync <= '0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], btn_in};
    end
  end

  // Any sample matching the current level restarts the stability count.
  always_comb begin
    toggle  = 1'b0;
    cnt_nxt = '0;
    if (s != level_o) begin
      if (cnt == CW'(DEBOUNCE_CYC - 1)) begin
        toggle  = 1'b1;
        cnt_nxt = '0;
      end else begin
        cnt_nxt = cnt + CW'(1);
      end
    end else begin
      cnt_nxt = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt       <= '0;
      level_o   <= 1'b0;
      press_o   <= 1'b0;
      release_o <= 1'b0;
    end else begin
      cnt       <= cnt_nxt;
      level_o   <= level_o ^ toggle;
      press_o   <= toggle & ~level_o;
      release_o <= toggle & level_o;
    end
  end

  if (REPEAT_DELAY > 0) begin : g_rpt
    localparam int RW = rpt_width(REPEAT_DELAY, REPEAT_RATE);

    logic [RW-1:0] rpt;
    logic [RW-1:0] rpt_inc;
    logic [RW-1:0] rpt_nxt;
    logic          fire;

    // Count while held; after the first repeat, fold back to DELAY every RATE cycles.
    always_comb begin
      rpt_inc = rpt + RW'(1);
      rpt_nxt = '0;
      fire    = 1'b0;
      if (level_o && !toggle) begin
        fire = (rpt_inc == RW'(REPEAT_DELAY)) ||
               (rpt_inc == RW'(REPEAT_DELAY + REPEAT_RATE));
        if (rpt_inc == RW'(REPEAT_DELAY + REPEAT_RATE)) begin
          rpt_nxt = RW'(REPEAT_DELAY);
        end else begin
          rpt_nxt = rpt_inc;
        end
      end else begin
        rpt_nxt = '0;
      end
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        rpt      <= '0;
        repeat_o <= 1'b0;
      end else begin
        rpt      <= rpt_nxt;
        repeat_o <= fire & repeat_en;
      end
    end
  end else begin : g_no_rpt
    logic unused_repeat_en;
    assign unused_repeat_en = repeat_en;
    assign repeat_o         = 1'b0;
  end

endmodule

// File: rtl/button_event_gen.sv
// Multi-channel debounced button event generator: N_CH independent channels.
module button_event_gen
  import button_pkg::*;
#(
  parameter int N_CH         = 4,
  parameter int SYNC_STAGES  = DEF_SYNC_STAGES,
  parameter int DEBOUNCE_CYC = DEF_DEBOUNCE_CYC,
  parameter int REPEAT_DELAY = 0,
  parameter int REPEAT_RATE  = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N_CH-1:0] btn_in,
  input  logic [N_CH-1:0] repeat_en,
  output logic [N_CH-1:0] level_o,
  output logic [N_CH-1:0] press_o,
  output logic [N_CH-1:0] release_o,
  output logic [N_CH-1:0] repeat_o
);

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    button_channel #(
      .SYNC_STAGES (SYNC_STAGES),
      .DEBOUNCE_CYC(DEBOUNCE_CYC),
      .REPEAT_DELAY(REPEAT_DELAY),
      .REPEAT_RATE (REPEAT_RATE)
    ) u_ch (
      .clk      (clk),
      .reset    (reset),
      .btn_in   (btn_in[i]),
      .repeat_en(repeat_en[i]),
      .level_o  (level_o[i]),
      .press_o  (press_o[i]),
      .release_o(release_o[i]),
      .repeat_o (repeat_o[i])
    );
  end

endmodule

// File: tb/tb_button_event_gen.sv
// Scoreboard bench: stimulus pushes per-edge expectations from a window-based
// reference model; a monitor pops and compares after every clock edge.
module tb_button_event_gen;

  localparam int N     = 4;
  localparam int SYNC  = 2;
  localparam int DEB   = 4;
  localparam int DELAY = 10;
  localparam int RATE  = 5;
  localparam int LAT   = SYNC + DEB - 1;  // edge index difference: raise step -> press edge

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [N-1:0] btn_in = '0;
  logic [N-1:0] repeat_en = '0;
  logic [N-1:0] level_o, press_o, release_o, repeat_o;

  button_event_gen #(
    .N_CH(N), .SYNC_STAGES(SYNC), .DEBOUNCE_CYC(DEB),
    .REPEAT_DELAY(DELAY), .REPEAT_RATE(RATE)
  ) dut (
    .clk(clk), .reset(reset), .btn_in(btn_in), .repeat_en(repeat_en),
    .level_o(level_o), .press_o(press_o), .release_o(release_o), .repeat_o(repeat_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    int           edge_n;
    logic [N-1:0] level;
    logic [N-1:0] press;
    logic [N-1:0] rel;
    logic [N-1:0] rpt;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference model state: raw input history, synchronised sample history, level, press edge
  bit   bh[N][$];
  bit   sh[N][$];
  bit   m_level[N];
  int   p_edge[N];
  int   edge_n = 0;

  // Monitor-side tallies of observed DUT pulses
  int   press_cnt[N];
  int   rel_cnt[N];
  int   rpt_cnt[N];
  int   last_press[N];
  int   last_rel[N];

  task automatic check(input string name, input int act, input int exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp_v, exp_v);
    end
  endtask

  task automatic step(input logic r, input logic [N-1:0] b, input logic [N-1:0] e);
    exp_t x;
    bit   s, flip, old, all_diff;
    int   d;
    @(negedge clk);
    x.level = '0; x.press = '0; x.rel = '0; x.rpt = '0;
    if (r && !reset) begin
      reset = 1'b1;
      #1;
      check("reset_async_clear", int'({level_o, press_o, release_o, repeat_o}), 0);
    end
    reset     = r;
    btn_in    = b;
    repeat_en = e;
    edge_n++;
    x.edge_n = edge_n;
    for (int c = 0; c < N; c++) begin
      if (r) begin
        bh[c].delete();
        sh[c].delete();
        m_level[c] = 1'b0;
      end else begin
        bh[c].push_front(b[c]);
        s = (bh[c].size() > SYNC) ? bh[c][SYNC] : 1'b0;
        if (bh[c].size() > SYNC + 1) void'(bh[c].pop_back());
        sh[c].push_front(s);
        if (sh[c].size() > DEB) void'(sh[c].pop_back());
        // Level flips once the last DEB synchronised samples all disagree with it.
        all_diff = (sh[c].size() == DEB);
        foreach (sh[c][k]) if (sh[c][k] == m_level[c]) all_diff = 1'b0;
        flip = all_diff;
        old  = m_level[c];
        if (flip && !old) p_edge[c] = edge_n;
        d = edge_n - p_edge[c];
        x.press[c] = flip && !old;
        x.rel[c]   = flip && old;
        x.rpt[c]   = old && !flip && e[c] && (d >= DELAY) && (((d - DELAY) % RATE) == 0);
        if (flip) m_level[c] = !old;
        x.level[c] = m_level[c];
      end
    end
    q.push_back(x);
  endtask

  task automatic idle(input int n, input logic [N-1:0] b, input logic [N-1:0] e);
    for (int i = 0; i < n; i++) step(1'b0, b, e);
  endtask

  // Monitor: compare every post-edge output set against the oldest expectation
  initial begin
    exp_t x;
    for (int c = 0; c < N; c++) begin
      press_cnt[c] = 0; rel_cnt[c] = 0; rpt_cnt[c] = 0; last_press[c] = 0; last_rel[c] = 0;
    end
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        x = q.pop_front();
        check($sformatf("level@%0d", x.edge_n), int'(level_o), int'(x.level));
        check($sformatf("press@%0d", x.edge_n), int'(press_o), int'(x.press));
        check($sformatf("release@%0d", x.edge_n), int'(release_o), int'(x.rel));
        check($sformatf("repeat@%0d", x.edge_n), int'(repeat_o), int'(x.rpt));
        for (int c = 0; c < N; c++) begin
          if (press_o[c])   begin press_cnt[c]++; last_press[c] = x.edge_n; end
          if (release_o[c]) begin rel_cnt[c]++;   last_rel[c]   = x.edge_n; end
          if (repeat_o[c])  rpt_cnt[c]++;
        end
      end
    end
  end

  initial begin
    int t0, t1, base_p, base_r, base_x, base_p1, base_p2;
    int run[N];
    bit cur[N];
    logic [N-1:0] b, e;

    for (int c = 0; c < N; c++) begin m_level[c] = 1'b0; p_edge[c] = 0; end
    for (int i = 0; i < 3; i++) step(1'b1, '0, '0);
    idle(4, '0, '0);

    // Clean press/release on ch0
    base_p = press_cnt[0]; base_r = rel_cnt[0];
    t0 = edge_n + 1;
    idle(26, 4'b0001, '0);
    t1 = edge_n + 1;
    idle(12, '0, '0);
    check("clean_press_latency", last_press[0] - t0, LAT);
    check("clean_release_latency", last_rel[0] - t1, LAT);
    check("clean_press_count", press_cnt[0] - base_p, 1);
    check("clean_release_count", rel_cnt[0] - base_r, 1);

    // Bounce rejection on ch1: 3-cycle runs never reach DEB
    base_p = press_cnt[1];
    for (int i = 0; i < 30; i++) step(1'b0, ((i / 3) % 2 == 0) ? 4'b0010 : 4'b0000, '0);
    idle(8, '0, '0);
    check("bounce_no_press", press_cnt[1] - base_p, 0);
    idle(12, 4'b0010, '0);
    idle(12, '0, '0);
    check("bounce_final_press", press_cnt[1] - base_p, 1);

    // Auto-repeat on ch2, enabled then disabled
    base_x = rpt_cnt[2]; base_p = press_cnt[2];
    idle(50, 4'b0100, 4'b0100);
    idle(12, '0, 4'b0100);
    check("repeat_enabled_fires", int'((rpt_cnt[2] - base_x) > 3), 1);
    base_x = rpt_cnt[2];
    idle(40, 4'b0100, '0);
    idle(12, '0, '0);
    check("repeat_disabled_silent", rpt_cnt[2] - base_x, 0);
    check("repeat_press_count", press_cnt[2] - base_p, 2);

    // Channel independence: ch0 clean, ch3 bounces for 4 cycles
    base_p1 = press_cnt[1]; base_p2 = press_cnt[2];
    for (int i = 0; i < 24; i++) step(1'b0, {(i >= 4) || (i < 2), 2'b00, 1'b1}, '0);
    idle(12, '0, '0);
    check("indep_ch3_delay", last_press[3] - last_press[0], 4);
    check("indep_ch1_ch2_silent", (press_cnt[1] - base_p1) + (press_cnt[2] - base_p2), 0);

    // Reset mid-hold on ch2 with repeats active
    base_x = rpt_cnt[2];
    idle(30, 4'b0100, 4'b0100);
    check("prereset_repeat", int'(rpt_cnt[2] > base_x), 1);
    step(1'b1, 4'b0100, 4'b0100);
    step(1'b1, 4'b0100, 4'b0100);
    t0 = edge_n + 1;
    idle(20, 4'b0100, 4'b0100);
    check("postreset_press_latency", last_press[2] - t0, LAT);
    idle(12, '0, '0);

    // Minimum width: DEB-1 cycles rejected, DEB cycles accepted
    base_p = press_cnt[0]; base_r = rel_cnt[0];
    idle(DEB - 1, 4'b0001, '0);
    idle(12, '0, '0);
    check("minwidth_short_rejected", press_cnt[0] - base_p, 0);
    idle(DEB, 4'b0001, '0);
    idle(14, '0, '0);
    check("minwidth_exact_press", press_cnt[0] - base_p, 1);
    check("minwidth_exact_release", rel_cnt[0] - base_r, 1);

    // Randomised runs with occasional reset
    for (int c = 0; c < N; c++) begin run[c] = 0; cur[c] = 1'b0; end
    e = '0;
    for (int i = 0; i < 700; i++) begin
      if (i % 60 == 0) e = N'($urandom);
      for (int c = 0; c < N; c++) begin
        if (run[c] == 0) begin
          cur[c] = !cur[c];
          run[c] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(12, 30))
                                               : int'($urandom_range(1, 7));
        end
        run[c]--;
        b[c] = cur[c];
      end
      step(($urandom_range(0, 199) == 0) ? 1'b1 : 1'b0, b, e);
    end
    idle(12, '0, '0);

    @(posedge clk);
    #2;
    check("queue_drained", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
